// File: rtl/sha256_padder_pkg.sv
// Shared definitions for the SHA-256 padder: state encoding, block geometry,
// the pad byte and the byte-swap used to place the big-endian length.
package sha256_padder_pkg;

  localparam int BLK_WORDS = 16;
  localparam int BLK_BYTES = 64;
  localparam int LEN_OFF   = 56;
  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_PAD,
    ST_SEND,
    ST_WAIT
  } state_t;

  typedef enum logic [1:0] {
    PAD_NONE,
    PAD_TAIL,
    PAD_EXTRA
  } pad_op_t;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/sha256_padder_if.sv
// Byte stream in, word stream and completion handshake toward the hash core.
// slave = padder side, master = producer/core side.
interface sha256_padder_if;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic        dat_vaild_o;
  logic [31:0] dat_lsb_o;
  logic        hash_busy_i;
  logic        irq_finish_i;
  logic        msg_done_o;

  modport slave (
    input  s_valid, s_data, s_last, hash_busy_i, irq_finish_i,
    output s_ready, dat_vaild_o, dat_lsb_o, msg_done_o
  );

  modport master (
    output s_valid, s_data, s_last, hash_busy_i, irq_finish_i,
    input  s_ready, dat_vaild_o, dat_lsb_o, msg_done_o
  );
endinterface

// File: rtl/sha256_pad_buf.sv
// 16 x 32-bit block buffer: byte-lane write, whole-buffer clear, length load
// into words 14/15, and a combinational word read port.
module sha256_pad_buf
  import sha256_padder_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_byte_we,
  input  logic [5:0]  i_byte_idx,
  input  logic [7:0]  i_byte_data,
  input  logic        i_len_we,
  input  logic [63:0] i_len,
  input  logic [3:0]  i_rd_idx,
  output logic [31:0] o_rd_word
);

  logic [31:0] r_mem [BLK_WORDS];

  // Later assignments win, so a byte written in the same cycle as a clear survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BLK_WORDS; i++) r_mem[i] <= '0;
    end else begin
      if (i_clr) begin
        for (int i = 0; i < BLK_WORDS; i++) r_mem[i] <= '0;
      end
      if (i_len_we) begin
        r_mem[LEN_OFF/4]     <= bswap32(i_len[63:32]);
        r_mem[LEN_OFF/4 + 1] <= bswap32(i_len[31:0]);
      end
      if (i_byte_we) begin
        r_mem[i_byte_idx[5:2]][{i_byte_idx[1:0], 3'b000} +: 8] <= i_byte_data;
      end
    end
  end

  assign o_rd_word = r_mem[i_rd_idx];

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs a byte stream into 512-bit blocks and appends
// the 0x80 marker and bit length. SHA256_PAD_LEN64_EN selects a 64-bit counter.
// state   | meaning
// ST_IDLE | no message in progress
// ST_FILL | collecting message bytes
// ST_PAD  | writing 0x80 / length into the buffer
// ST_SEND | streaming 16 words to the core
// ST_WAIT | core compressing the block
module sha256_padder
  import sha256_padder_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  sha256_padder_if.slave bus,
  output logic           busy_o
);

  localparam logic [5:0] LAST_OFF = 6'(BLK_BYTES - 1);
  localparam logic [5:0] TAIL_LIM = 6'(LEN_OFF - 1);
  localparam logic [3:0] LAST_WRD = 4'(BLK_WORDS - 1);

  state_t      r_state, w_state_nxt;
  pad_op_t     r_pad_op;
  logic [5:0]  r_off;
  logic [3:0]  r_word;
  logic        r_tail80, r_tail_len, r_extra, r_extra80, r_final, r_msg_done;
  logic        w_acc, w_ready, w_valid, w_clr, w_byte_we, w_len_we;
  logic [5:0]  w_byte_idx;
  logic [7:0]  w_byte_data;
  logic [31:0] w_rd_word;
  logic [63:0] w_len64;

`ifdef SHA256_PAD_LEN64_EN
  localparam int LEN_W = 64;
  logic [LEN_W-1:0] r_len;
  assign w_len64 = r_len;
`else
  localparam int LEN_W = 32;
  logic [LEN_W-1:0] r_len;
  assign w_len64 = {32'h0, r_len};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_valid     = 1'b0;
    w_acc       = 1'b0;
    w_clr       = 1'b0;
    w_byte_we   = 1'b0;
    w_byte_idx  = r_off;
    w_byte_data = bus.s_data;
    w_len_we    = 1'b0;
    case (r_state)
      ST_IDLE, ST_FILL: begin
        w_ready = 1'b1;
        if (bus.s_valid) begin
          w_acc     = 1'b1;
          w_byte_we = 1'b1;
          w_clr     = (r_off == 6'd0);
          if (bus.s_last)             w_state_nxt = ST_PAD;
          else if (r_off == LAST_OFF) w_state_nxt = bus.hash_busy_i ? ST_PAD : ST_SEND;
          else                        w_state_nxt = ST_FILL;
        end
      end
      ST_PAD: begin
        // Writes are idempotent, so holding here while the core is busy is harmless.
        case (r_pad_op)
          PAD_TAIL: begin
            w_byte_we   = r_tail80;
            w_byte_data = PAD_BYTE;
            w_len_we    = r_tail_len;
          end
          PAD_EXTRA: begin
            w_clr       = 1'b1;
            w_len_we    = 1'b1;
            w_byte_we   = r_extra80;
            w_byte_idx  = '0;
            w_byte_data = PAD_BYTE;
          end
          default: ;
        endcase
        if (!bus.hash_busy_i) w_state_nxt = ST_SEND;
      end
      ST_SEND: begin
        w_valid = 1'b1;
        if (r_word == LAST_WRD) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.irq_finish_i) begin
          if (r_final)      w_state_nxt = ST_IDLE;
          else if (r_extra) w_state_nxt = ST_PAD;
          else              w_state_nxt = ST_FILL;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_off      <= '0;
      r_word     <= '0;
      r_len      <= '0;
      r_pad_op   <= PAD_NONE;
      r_tail80   <= 1'b0;
      r_tail_len <= 1'b0;
      r_extra    <= 1'b0;
      r_extra80  <= 1'b0;
      r_final    <= 1'b0;
      r_msg_done <= 1'b0;
    end else begin
      r_msg_done <= 1'b0;
      if (w_acc) begin
        r_len <= r_len + LEN_W'(8);
        r_off <= r_off + 6'd1;
        if (bus.s_last) begin
          // Offset n of the final byte decides where 0x80 and the length land.
          r_pad_op   <= PAD_TAIL;
          r_tail80   <= (r_off != LAST_OFF);
          r_tail_len <= (r_off < TAIL_LIM);
          r_final    <= (r_off < TAIL_LIM);
          r_extra    <= (r_off >= TAIL_LIM);
          r_extra80  <= (r_off == LAST_OFF);
        end else if (r_off == LAST_OFF) begin
          r_pad_op <= PAD_NONE;
          r_final  <= 1'b0;
          r_extra  <= 1'b0;
        end
      end
      if (r_state == ST_SEND) r_word <= r_word + 4'd1;
      if (r_state == ST_WAIT && bus.irq_finish_i) begin
        r_off <= '0;
        if (r_final) begin
          r_msg_done <= 1'b1;
          r_len      <= '0;
          r_final    <= 1'b0;
        end else if (r_extra) begin
          r_pad_op <= PAD_EXTRA;
          r_extra  <= 1'b0;
          r_final  <= 1'b1;
        end
      end
    end
  end

  sha256_pad_buf u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (w_clr),
    .i_byte_we   (w_byte_we),
    .i_byte_idx  (w_byte_idx),
    .i_byte_data (w_byte_data),
    .i_len_we    (w_len_we),
    .i_len       (w_len64),
    .i_rd_idx    (r_word),
    .o_rd_word   (w_rd_word)
  );

  assign bus.s_ready     = w_ready;
  assign bus.dat_vaild_o = w_valid;
  assign bus.dat_lsb_o   = w_valid ? w_rd_word : '0;
  assign bus.msg_done_o  = r_msg_done;
  assign busy_o          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sha256_padder.sv
// Bench for sha256_padder: a core model consumes words, runs SHA-256 compression
// and checks each word against a queue built from standard SHA-256 padding.
`timescale 1ns/1ps
module tb_sha256_padder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy_o;
  always #5 clk = ~clk;

  sha256_padder_if u_if();

  sha256_padder dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (u_if.slave),
    .busy_o (busy_o)
  );

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [31:0] H_IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q [$];
  int          done_cnt = 0;
  int          blk_cnt = 0;
  int          spur_req = 0;
  logic [31:0] last_blk [16];
  logic [31:0] w_cur [16];
  logic [31:0] h_st [8];
  logic [31:0] last_h0 = '0;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] tb_swap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic void compress();
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = tb_swap(w_cur[i]);
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    a = h_st[0]; b = h_st[1]; c = h_st[2]; d = h_st[3];
    e = h_st[4]; f = h_st[5]; g = h_st[6]; h = h_st[7];
    for (int i = 0; i < 64; i++) begin
      s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
      t1 = h + s1 + ((e & f) ^ (~e & g)) + K[i] + w[i];
      s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
      t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    h_st[0] += a; h_st[1] += b; h_st[2] += c; h_st[3] += d;
    h_st[4] += e; h_st[5] += f; h_st[6] += g; h_st[7] += h;
  endfunction

  // Core model: owns hash_busy_i / irq_finish_i.
  initial begin : core_model
    int wi;
    int run;
    int spur_seen;
    logic [31:0] exp_w;
    wi = 0; run = 0; spur_seen = 0;
    u_if.hash_busy_i = 1'b0;
    u_if.irq_finish_i = 1'b0;
    h_st = H_IV;
    forever begin
      @(negedge clk);
      u_if.irq_finish_i = 1'b0;
      if (!rst_n) begin
        wi = 0; run = 0; h_st = H_IV; u_if.hash_busy_i = 1'b0;
        continue;
      end
      if (u_if.msg_done_o) begin
        done_cnt++;
        last_h0 = h_st[0];
        h_st = H_IV;
      end
      if (spur_req != spur_seen) begin
        spur_seen = spur_req;
        u_if.irq_finish_i = 1'b1;
      end
      if (u_if.dat_vaild_o) begin
        run++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL word_unexpected got %h expected none", u_if.dat_lsb_o);
        end else begin
          exp_w = exp_q.pop_front();
          if (u_if.dat_lsb_o !== exp_w) begin
            errors++;
            $display("FAIL word%0d got %h expected %h", wi, u_if.dat_lsb_o, exp_w);
          end
        end
        w_cur[wi] = u_if.dat_lsb_o;
        wi++;
        if (wi == 16) begin
          wi = 0;
          compress();
          last_blk = w_cur;
          blk_cnt++;
          checks++;
          if (u_if.s_ready !== 1'b0) begin
            errors++;
            $display("FAIL s_ready_in_send got %b expected 0", u_if.s_ready);
          end
          u_if.hash_busy_i = 1'b1;
          repeat (6) @(negedge clk);
          u_if.hash_busy_i = 1'b0;
          u_if.irq_finish_i = 1'b1;
        end
      end else if (run != 0) begin
        checks++;
        if (run != 16) begin
          errors++;
          $display("FAIL valid_run got %0d expected 16", run);
        end
        run = 0;
      end
    end
  end

  task automatic expect_msg(input logic [7:0] msg [$]);
    logic [7:0] p [$];
    longint unsigned bits;
    p = msg;
    bits = longint'(msg.size()) * 8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(8'(bits >> (8 * i)));
    for (int k = 0; k < p.size() / 4; k++)
      exp_q.push_back({p[4*k+3], p[4*k+2], p[4*k+1], p[4*k]});
  endtask

  task automatic push_bytes(input logic [7:0] msg [$], input int lo, input int hi);
    int guard;
    for (int i = lo; i <= hi; i++) begin
      u_if.s_valid = 1'b1;
      u_if.s_data  = msg[i];
      u_if.s_last  = (i == msg.size() - 1);
      guard = 0;
      while (!u_if.s_ready && guard < 5000) begin
        @(negedge clk);
        guard++;
      end
      checks++;
      if (!u_if.s_ready) begin
        errors++;
        $display("FAIL byte%0d_accept got s_ready %b expected 1", i, u_if.s_ready);
        break;
      end
      @(negedge clk);
    end
    u_if.s_valid = 1'b0;
    u_if.s_last  = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    int g;
    g = 0;
    while (done_cnt < target && g < 5000) begin
      @(negedge clk);
      g++;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (done_cnt !== target) begin
      errors++;
      $display("FAIL %s_msg_done got %0d expected %0d", name, done_cnt, target);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_words_left got %0d expected 0", name, exp_q.size());
    end
  endtask

  task automatic rand_msg(input int n, output logic [7:0] msg [$]);
    msg = {};
    for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
  endtask

  task automatic test_reset();
    u_if.s_valid = 1'b0; u_if.s_data = '0; u_if.s_last = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (u_if.dat_vaild_o !== 1'b0 || u_if.dat_lsb_o !== 32'h0 || u_if.msg_done_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got valid %b data %h done %b busy %b expected 0", u_if.dat_vaild_o, u_if.dat_lsb_o, u_if.msg_done_o, busy_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (u_if.s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_s_ready got %b expected 1", u_if.s_ready);
    end
  endtask

  task automatic test_abc(input string name);
    logic [7:0] msg [$];
    int b0, d0;
    msg = '{8'h61, 8'h62, 8'h63};
    b0 = blk_cnt; d0 = done_cnt;
    expect_msg(msg);
    push_bytes(msg, 0, 2);
    wait_done(d0 + 1, name);
    checks++;
    if (blk_cnt - b0 != 1 || last_blk[0] !== 32'h80636261 || last_blk[15] !== 32'h18000000) begin
      errors++;
      $display("FAIL %s_block got n=%0d w0 %h w15 %h expected n=1 w0 80636261 w15 18000000", name, blk_cnt - b0, last_blk[0], last_blk[15]);
    end
    checks++;
    if (last_h0 !== 32'hba7816bf) begin
      errors++;
      $display("FAIL %s_hash0 got %h expected ba7816bf", name, last_h0);
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy_after got %b expected 0", name, busy_o);
    end
  endtask

  task automatic test_len55();
    logic [7:0] msg [$];
    int b0;
    rand_msg(55, msg);
    b0 = blk_cnt;
    expect_msg(msg);
    push_bytes(msg, 0, 54);
    wait_done(done_cnt + 1, "len55");
    checks++;
    if (blk_cnt - b0 != 1 || last_blk[13][31:24] !== 8'h80 || last_blk[15] !== 32'hb8010000) begin
      errors++;
      $display("FAIL len55_block got n=%0d w13 %h w15 %h expected n=1 w13[31:24] 80 w15 b8010000", blk_cnt - b0, last_blk[13], last_blk[15]);
    end
  endtask

  task automatic test_len56();
    logic [7:0] msg [$];
    logic [31:0] acc;
    int b0;
    rand_msg(56, msg);
    b0 = blk_cnt;
    expect_msg(msg);
    push_bytes(msg, 0, 55);
    wait_done(done_cnt + 1, "len56");
    acc = '0;
    for (int i = 0; i < 15; i++) acc |= last_blk[i];
    checks++;
    if (blk_cnt - b0 != 2 || acc !== 32'h0 || last_blk[15] !== 32'hc0010000) begin
      errors++;
      $display("FAIL len56_block got n=%0d or0_14 %h w15 %h expected n=2 0 c0010000", blk_cnt - b0, acc, last_blk[15]);
    end
  endtask

  task automatic test_len64();
    logic [7:0] msg [$];
    int b0, d0;
    rand_msg(64, msg);
    b0 = blk_cnt; d0 = done_cnt;
    expect_msg(msg);
    push_bytes(msg, 0, 63);
    wait_done(d0 + 1, "len64");
    checks++;
    if (blk_cnt - b0 != 2 || last_blk[0] !== 32'h00000080 || last_blk[15] !== 32'h00020000) begin
      errors++;
      $display("FAIL len64_block got n=%0d w0 %h w15 %h expected n=2 00000080 00020000", blk_cnt - b0, last_blk[0], last_blk[15]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] m1 [$];
    logic [7:0] m2 [$];
    int b0, d0;
    rand_msg(130, m1);
    m2 = '{8'h61, 8'h62, 8'h63};
    b0 = blk_cnt; d0 = done_cnt;
    expect_msg(m1);
    expect_msg(m2);
    push_bytes(m1, 0, 129);
    push_bytes(m2, 0, 2);
    wait_done(d0 + 2, "b2b");
    checks++;
    if (blk_cnt - b0 != 4 || last_h0 !== 32'hba7816bf) begin
      errors++;
      $display("FAIL b2b_blocks got n=%0d h0 %h expected n=4 ba7816bf", blk_cnt - b0, last_h0);
    end
  endtask

  task automatic test_spurious_irq();
    logic [7:0] msg [$];
    int d0;
    d0 = done_cnt;
    spur_req++;
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt !== d0 || busy_o !== 1'b0 || u_if.s_ready !== 1'b1) begin
      errors++;
      $display("FAIL spur_idle got done %0d busy %b ready %b expected %0d 0 1", done_cnt, busy_o, u_if.s_ready, d0);
    end
    rand_msg(5, msg);
    expect_msg(msg);
    push_bytes(msg, 0, 1);
    spur_req++;
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt !== d0 || busy_o !== 1'b1 || u_if.s_ready !== 1'b1) begin
      errors++;
      $display("FAIL spur_fill got done %0d busy %b ready %b expected %0d 1 1", done_cnt, busy_o, u_if.s_ready, d0);
    end
    push_bytes(msg, 2, 4);
    wait_done(d0 + 1, "spur");
  endtask

  task automatic test_reset_mid_send();
    logic [7:0] msg [$];
    int nv, g;
    msg = '{8'h61, 8'h62, 8'h63};
    expect_msg(msg);
    push_bytes(msg, 0, 2);
    nv = 0; g = 0;
    while (nv < 8 && g < 500) begin
      @(negedge clk);
      if (u_if.dat_vaild_o) nv++;
      g++;
    end
    checks++;
    if (nv != 8) begin
      errors++;
      $display("FAIL rst_reach_word7 got %0d valid cycles expected 8", nv);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (u_if.dat_vaild_o !== 1'b0 || u_if.dat_lsb_o !== 32'h0) begin
      errors++;
      $display("FAIL rst_async_drop got valid %b data %h expected 0 0", u_if.dat_vaild_o, u_if.dat_lsb_o);
    end
    repeat (3) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || u_if.s_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_after got busy %b ready %b expected 0 1", busy_o, u_if.s_ready);
    end
    test_abc("abc_after_rst");
  endtask

  initial begin
    test_reset();
    test_abc("abc");
    test_len55();
    test_len56();
    test_len64();
    test_back_to_back();
    test_spurious_irq();
    test_reset_mid_send();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
